// File: rtl/ex_stage_alu_if.sv
`default_nettype none
// ============================================================================
// ex_stage_alu_if : ID/EX -> EX -> MEM handshake and payload bundle
// Revision 1.0
// ============================================================================
interface ex_stage_alu_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RD_W   = 5
);
   // ID/EX side
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        Operation;
   logic [DATA_W-1:0] SrcA;
   logic [DATA_W-1:0] SrcB;
   logic [DATA_W-1:0] store_data;
   logic [RD_W-1:0]   rd_in;
   logic              reg_write_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              is_branch;
   logic [PC_W-1:0]   branch_target;
   logic              flush;

   // EX/MEM side
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_result;
   logic              zero;
   logic [DATA_W-1:0] store_data_q;
   logic [RD_W-1:0]   rd_q;
   logic              reg_write_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              illegal_op;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, store_data, rd_in,
             reg_write_in, mem_read_in, mem_write_in, is_branch,
             branch_target, flush, out_ready,
      output in_ready, out_valid, alu_result, zero, store_data_q, rd_q,
             reg_write_q, mem_read_q, mem_write_q, illegal_op,
             redirect, redirect_pc
   );

   modport master (
      output in_valid, Operation, SrcA, SrcB, store_data, rd_in,
             reg_write_in, mem_read_in, mem_write_in, is_branch,
             branch_target, flush, out_ready,
      input  in_ready, out_valid, alu_result, zero, store_data_q, rd_q,
             reg_write_q, mem_read_q, mem_write_q, illegal_op,
             redirect, redirect_pc
   );
endinterface
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
// ex_stage_alu : RISC-V execute stage - ALU, BEQ/BNE resolution, EX/MEM register
// Revision 1.0
// ============================================================================
module ex_stage_alu #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RD_W   = 5
) (
   input  logic          clk,
   input  logic          reset,
   ex_stage_alu_if.slave bus
);
   localparam logic [3:0] c_OP_AND = 4'b0000;
   localparam logic [3:0] c_OP_SUB = 4'b0001;
   localparam logic [3:0] c_OP_ADD = 4'b0010;
   localparam logic [3:0] c_OP_BNE = 4'b0011;
   localparam logic [3:0] c_OP_OR  = 4'b0100;
   localparam logic [3:0] c_OP_XOR = 4'b0101;
   localparam logic [3:0] c_OP_BEQ = 4'b1000;

   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] result_d;
   logic              op_legal;
   logic              br_op;
   logic              br_cond;
   logic              illegal_d;
   logic              taken_d;
   logic              ctl_en;
   logic              in_ready;
   logic              accept;

   logic              out_valid_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic [DATA_W-1:0] sdata_q;
   logic [RD_W-1:0]   rd_reg_q;
   logic              rw_q;
   logic              mr_q;
   logic              mw_q;
   logic              illegal_q;
   logic              redirect_q;
   logic [PC_W-1:0]   redirect_pc_q;

   assign diff = bus.SrcA - bus.SrcB;

   always_comb begin
      result_d = '0;
      op_legal = 1'b1;
      br_op    = 1'b0;
      br_cond  = 1'b0;
      case (bus.Operation)
         c_OP_AND: result_d = bus.SrcA & bus.SrcB;
         c_OP_SUB: result_d = diff;
         c_OP_ADD: result_d = bus.SrcA + bus.SrcB;
         c_OP_OR:  result_d = bus.SrcA | bus.SrcB;
         c_OP_XOR: result_d = bus.SrcA ^ bus.SrcB;
         c_OP_BEQ: begin
            result_d = diff;
            br_op    = 1'b1;
            br_cond  = (bus.SrcA == bus.SrcB);
         end
         c_OP_BNE: begin
            result_d = diff;
            br_op    = 1'b1;
            br_cond  = (bus.SrcA != bus.SrcB);
         end
         default:  op_legal = 1'b0;
      endcase
   end

   // A branch flag paired with a non-branch opcode is treated as malformed.
   assign illegal_d = !op_legal || (bus.is_branch && !br_op);
   assign taken_d   = bus.is_branch && br_op && br_cond;
   assign ctl_en    = !illegal_d && !bus.is_branch;

   assign in_ready  = !out_valid_q || bus.out_ready;
   assign accept    = bus.in_valid && in_ready && !bus.flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         result_q      <= '0;
         zero_q        <= 1'b0;
         sdata_q       <= '0;
         rd_reg_q      <= '0;
         rw_q          <= 1'b0;
         mr_q          <= 1'b0;
         mw_q          <= 1'b0;
         illegal_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else if (bus.flush) begin
         // Data fields are left stale; out_valid qualifies them downstream.
         out_valid_q <= 1'b0;
         redirect_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q   <= 1'b1;
         result_q      <= result_d;
         zero_q        <= (result_d == '0);
         sdata_q       <= bus.store_data;
         rd_reg_q      <= bus.rd_in;
         rw_q          <= bus.reg_write_in && ctl_en;
         mr_q          <= bus.mem_read_in  && ctl_en;
         mw_q          <= bus.mem_write_in && ctl_en;
         illegal_q     <= illegal_d;
         redirect_q    <= taken_d;
         redirect_pc_q <= bus.branch_target;
      end else begin
         redirect_q <= 1'b0;
         if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.alu_result   = result_q;
   assign bus.zero         = zero_q;
   assign bus.store_data_q = sdata_q;
   assign bus.rd_q         = rd_reg_q;
   assign bus.reg_write_q  = rw_q;
   assign bus.mem_read_q   = mr_q;
   assign bus.mem_write_q  = mw_q;
   assign bus.illegal_op   = illegal_q;
   assign bus.redirect     = redirect_q;
   assign bus.redirect_pc  = redirect_pc_q;
endmodule
`default_nettype wire
